// File: rtl/led_snake_pattern_ctrl.sv
// led_snake_pattern_ctrl: animation sequencer for the 8-LED WS2812 stripe driver.
// Renders a moving snake (full-colour head, half-brightness tail) into the
// driver's eight frame words, advancing once every STEP_DIV frame requests.
//
// Ports:
//   clk, rst              - system clock, asynchronous active-high reset
//   new_frames_set_rqst   - driver request level; only its rising edge is used
//   start / stop          - one-cycle control pulses (stop wins over start)
//   color, len, dir,      - head colour, snake length, initial direction,
//   bounce                  wrap (0) / bounce (1) mode; latched on start
//   led0..led7            - registered frame words to the driver
//   head_pos              - current head register
//   busy                  - high from accepted start until the blanking frame
//   frame_update          - one-cycle pulse in the cycle the ledN words change
module led_snake_pattern_ctrl #(
   parameter int unsigned STEP_DIV = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        new_frames_set_rqst,
   input  logic        start,
   input  logic        stop,
   input  logic [23:0] color,
   input  logic [3:0]  len,
   input  logic        dir,
   input  logic        bounce,
   output logic [23:0] led0,
   output logic [23:0] led1,
   output logic [23:0] led2,
   output logic [23:0] led3,
   output logic [23:0] led4,
   output logic [23:0] led5,
   output logic [23:0] led6,
   output logic [23:0] led7,
   output logic [2:0]  head_pos,
   output logic        busy,
   output logic        frame_update
);

   localparam int unsigned NLED = 8;
   localparam int unsigned CW   = 24;
   localparam int unsigned DIVW = 16;
   localparam int unsigned HW   = 3;
   localparam int unsigned LW   = 4;
   localparam logic [DIVW-1:0] DIV_LAST = DIVW'(STEP_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t          state_q;
   logic            rqst_q;        // delayed request level for edge detection
   logic [CW-1:0]   color_q;
   logic [LW-1:0]   len_q;         // clamped to 1..8
   logic            mov_dn_q;
   logic            bounce_q;
   logic [HW-1:0]   head_q;
   logic [DIVW-1:0] div_cnt_q;
   logic [CW-1:0]   led_q [NLED];
   logic            busy_q;
   logic            frame_update_q;

   logic            req_e_c;
   logic [LW-1:0]   len_clamp_c;
   logic [CW-1:0]   frame_d [NLED];
   logic [HW-1:0]   head_adv_d;
   logic            mov_dn_adv_d;

   // One LED of the frame. The 4-bit difference carries the modulo-8 distance
   // in its low bits and, in bounce mode, the sign (LED ahead of head) in bit 3.
   function automatic logic [CW-1:0] render_led(
      input logic [HW-1:0] idx,
      input logic [HW-1:0] head,
      input logic          dn,
      input logic          bnc,
      input logic [LW-1:0] ln,
      input logic [CW-1:0] c
   );
      logic [LW-1:0] d_s;
      logic          lit;
      d_s = dn ? ({1'b0, idx} - {1'b0, head}) : ({1'b0, head} - {1'b0, idx});
      lit = ({1'b0, d_s[HW-1:0]} < ln) && !(bnc && d_s[LW-1]);
      if (!lit) begin
         render_led = '0;
      end else if (d_s[HW-1:0] == '0) begin
         render_led = c;
      end else begin
         render_led = (c >> 1) & 24'h7F7F7F;
      end
   endfunction

   assign req_e_c = new_frames_set_rqst & ~rqst_q;

   // Length clamp: 0 behaves as 1, anything above 8 as 8.
   always_comb begin
      len_clamp_c = len;
      if (len == '0) begin
         len_clamp_c = LW'(1);
      end else if (len > LW'(NLED)) begin
         len_clamp_c = LW'(NLED);
      end
   end

   // Frame rendered from the current head and direction.
   always_comb begin
      for (int unsigned i = 0; i < NLED; i++) begin
         frame_d[i] = render_led(HW'(i), head_q, mov_dn_q, bounce_q, len_q, color_q);
      end
   end

   // Next head position and direction after one step.
   always_comb begin
      head_adv_d   = head_q;
      mov_dn_adv_d = mov_dn_q;
      if (!bounce_q) begin
         head_adv_d = mov_dn_q ? head_q - HW'(1) : head_q + HW'(1);
      end else if (!mov_dn_q) begin
         if (head_q == HW'(NLED - 1)) begin
            mov_dn_adv_d = 1'b1;
            head_adv_d   = HW'(NLED - 2);
         end else begin
            head_adv_d = head_q + HW'(1);
         end
      end else begin
         if (head_q == '0) begin
            mov_dn_adv_d = 1'b0;
            head_adv_d   = HW'(1);
         end else begin
            head_adv_d = head_q - HW'(1);
         end
      end
   end

   // Sequencer FSM with registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= ST_IDLE;
         rqst_q         <= 1'b0;
         color_q        <= '0;
         len_q          <= LW'(1);
         mov_dn_q       <= 1'b0;
         bounce_q       <= 1'b0;
         head_q         <= '0;
         div_cnt_q      <= '0;
         led_q          <= '{default: '0};
         busy_q         <= 1'b0;
         frame_update_q <= 1'b0;
      end else begin
         rqst_q         <= new_frames_set_rqst;
         frame_update_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (start && !stop) begin
                  color_q   <= color;
                  len_q     <= len_clamp_c;
                  mov_dn_q  <= dir;
                  bounce_q  <= bounce;
                  head_q    <= dir ? HW'(NLED - 1) : '0;
                  div_cnt_q <= '0;
                  busy_q    <= 1'b1;
                  state_q   <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (req_e_c) begin
                  led_q          <= frame_d;
                  frame_update_q <= 1'b1;
                  if (div_cnt_q == DIV_LAST) begin
                     div_cnt_q <= '0;
                     head_q    <= head_adv_d;
                     mov_dn_q  <= mov_dn_adv_d;
                  end else begin
                     div_cnt_q <= div_cnt_q + DIVW'(1);
                  end
               end
               if (stop) begin
                  state_q <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               // Last frame is held until the next request, then blanked.
               if (req_e_c) begin
                  led_q          <= '{default: '0};
                  frame_update_q <= 1'b1;
                  busy_q         <= 1'b0;
                  head_q         <= '0;
                  div_cnt_q      <= '0;
                  state_q        <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign led0         = led_q[0];
   assign led1         = led_q[1];
   assign led2         = led_q[2];
   assign led3         = led_q[3];
   assign led4         = led_q[4];
   assign led5         = led_q[5];
   assign led6         = led_q[6];
   assign led7         = led_q[7];
   assign head_pos     = head_q;
   assign busy         = busy_q;
   assign frame_update = frame_update_q;

endmodule

// File: tb/tb_led_snake_pattern_ctrl.sv
// Bench for led_snake_pattern_ctrl: two instances (STEP_DIV=1 and STEP_DIV=4)
// share all stimulus; a scoreboard queue per instance holds expected frames.
module tb_led_snake_pattern_ctrl;

   typedef struct packed {
      logic [2:0]       head;
      logic [7:0][23:0] leds;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst, rqst, start, stop, dir, bounce;
   logic [23:0] color;
   logic [3:0]  len;
   logic [23:0] la [8];
   logic [23:0] lb [8];
   logic [2:0]  hpa, hpb;
   logic        bza, bzb, fua, fub;

   exp_t qa[$];
   exp_t qb[$];
   int checks = 0;
   int errors = 0;

   // Reference model state per instance: st 0=idle 1=run 2=drain
   int          m_st   [2];
   int          m_head [2];
   bit          m_dn   [2];
   int          m_div  [2];
   int          m_sd   [2];
   logic [23:0] m_color;
   int          m_len;
   bit          m_bnc;

   logic [7:0][23:0] prev_a, prev_b;

   always #20 clk = ~clk;

   led_snake_pattern_ctrl #(.STEP_DIV(1)) u_div1 (
      .clk(clk), .rst(rst), .new_frames_set_rqst(rqst), .start(start), .stop(stop),
      .color(color), .len(len), .dir(dir), .bounce(bounce),
      .led0(la[0]), .led1(la[1]), .led2(la[2]), .led3(la[3]),
      .led4(la[4]), .led5(la[5]), .led6(la[6]), .led7(la[7]),
      .head_pos(hpa), .busy(bza), .frame_update(fua));

   led_snake_pattern_ctrl #(.STEP_DIV(4)) u_div4 (
      .clk(clk), .rst(rst), .new_frames_set_rqst(rqst), .start(start), .stop(stop),
      .color(color), .len(len), .dir(dir), .bounce(bounce),
      .led0(lb[0]), .led1(lb[1]), .led2(lb[2]), .led3(lb[3]),
      .led4(lb[4]), .led5(lb[5]), .led6(lb[6]), .led7(lb[7]),
      .head_pos(hpb), .busy(bzb), .frame_update(fub));

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0][23:0] pack8(input logic [23:0] l [8]);
      logic [7:0][23:0] f;
      for (int i = 0; i < 8; i++) f[i] = l[i];
      return f;
   endfunction

   // Snake body walked backwards from the head, one segment per LED.
   function automatic logic [7:0][23:0] model_frame(input int head, input bit dn,
                                                    input bit bnc, input int ln,
                                                    input logic [23:0] c);
      logic [7:0][23:0] f;
      f = '0;
      for (int k = 0; k < ln; k++) begin
         int p;
         p = dn ? head + k : head - k;
         if (!bnc) p = ((p % 8) + 8) % 8;
         if (p >= 0 && p <= 7) f[p] = (k == 0) ? c : {1'b0, c[23:17], 1'b0, c[15:9], 1'b0, c[7:1]};
      end
      return f;
   endfunction

   task automatic model_step(input int d);
      if (!m_bnc) begin
         m_head[d] = m_dn[d] ? (m_head[d] + 7) % 8 : (m_head[d] + 1) % 8;
      end else if (!m_dn[d]) begin
         if (m_head[d] == 7) begin m_dn[d] = 1'b1; m_head[d] = 6; end
         else m_head[d] = m_head[d] + 1;
      end else begin
         if (m_head[d] == 0) begin m_dn[d] = 1'b0; m_head[d] = 1; end
         else m_head[d] = m_head[d] - 1;
      end
   endtask

   task automatic mon_pop(input int d, input logic [7:0][23:0] f, input logic [2:0] hp);
      exp_t e;
      if (d == 0) begin
         chk("update_expected_a", 192'(qa.size() != 0), 192'(1));
         if (qa.size() != 0) begin
            e = qa.pop_front();
            chk("frame_a", 192'(f), 192'(e.leds));
            chk("head_pos_a", 192'(hp), 192'(e.head));
         end
      end else begin
         chk("update_expected_b", 192'(qb.size() != 0), 192'(1));
         if (qb.size() != 0) begin
            e = qb.pop_front();
            chk("frame_b", 192'(f), 192'(e.leds));
            chk("head_pos_b", 192'(hp), 192'(e.head));
         end
      end
   endtask

   // Monitor: pops on frame_update, otherwise frames must hold still.
   always @(negedge clk) begin
      if (!rst) begin
         if (fua) mon_pop(0, pack8(la), hpa);
         else     chk("led_stable_a", 192'(pack8(la)), 192'(prev_a));
         if (fub) mon_pop(1, pack8(lb), hpb);
         else     chk("led_stable_b", 192'(pack8(lb)), 192'(prev_b));
      end
      prev_a = pack8(la);
      prev_b = pack8(lb);
   end

   task automatic do_start(input logic [23:0] c, input logic [3:0] l, input bit dr,
                           input bit bn, input bit with_stop);
      @(negedge clk);
      color = c; len = l; dir = dr; bounce = bn; start = 1'b1; stop = with_stop;
      if (!with_stop) begin
         m_color = c;
         m_len   = (l == 4'd0) ? 1 : ((l > 4'd8) ? 8 : int'(l));
         m_bnc   = bn;
         for (int d = 0; d < 2; d++) begin
            if (m_st[d] == 0) begin
               m_st[d] = 1; m_head[d] = dr ? 7 : 0; m_dn[d] = dr; m_div[d] = 0;
            end
         end
      end
      @(negedge clk);
      start = 1'b0; stop = 1'b0;
   endtask

   task automatic do_stop();
      @(negedge clk);
      stop = 1'b1;
      for (int d = 0; d < 2; d++) if (m_st[d] == 1) m_st[d] = 2;
      @(negedge clk);
      stop = 1'b0;
   endtask

   // One request edge (level held for 'hold' cycles), optionally with stop.
   task automatic req_edge(input bit with_stop, input int hold);
      exp_t e;
      int   n;
      @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         if (m_st[d] == 1) begin
            e.leds = model_frame(m_head[d], m_dn[d], m_bnc, m_len, m_color);
            if (m_div[d] == m_sd[d] - 1) begin m_div[d] = 0; model_step(d); end
            else m_div[d] = m_div[d] + 1;
            e.head = 3'(m_head[d]);
            if (d == 0) qa.push_back(e); else qb.push_back(e);
            if (with_stop) m_st[d] = 2;
         end else if (m_st[d] == 2) begin
            e = '0;
            if (d == 0) qa.push_back(e); else qb.push_back(e);
            m_st[d] = 0; m_head[d] = 0; m_div[d] = 0;
         end
      end
      rqst = 1'b1; stop = with_stop;
      @(negedge clk);
      stop = 1'b0;
      repeat (hold - 1) @(negedge clk);
      rqst = 1'b0;
      @(negedge clk);
      n = 0;
      while ((qa.size() != 0 || qb.size() != 0) && n < 6) begin
         @(negedge clk);
         n++;
      end
      chk("edge_drained", 192'(qa.size() + qb.size()), 192'(0));
   endtask

   initial begin
      #2ms;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      int n7;
      rst = 1'b1; rqst = 1'b0; start = 1'b0; stop = 1'b0;
      color = '0; len = '0; dir = 1'b0; bounce = 1'b0;
      m_sd[0] = 1; m_sd[1] = 4;
      for (int d = 0; d < 2; d++) begin m_st[d] = 0; m_head[d] = 0; m_dn[d] = 0; m_div[d] = 0; end
      m_color = '0; m_len = 1; m_bnc = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_leds_a", 192'(pack8(la)), 192'(0));
      chk("rst_leds_b", 192'(pack8(lb)), 192'(0));
      chk("rst_head", 192'(hpa), 192'(0));
      chk("rst_busy", 192'(bza), 192'(0));
      chk("rst_fu", 192'(fua), 192'(0));
      rst = 1'b0;
      @(negedge clk);

      // Wrap forward
      do_start(24'hFF8040, 4'd3, 1'b0, 1'b0, 1'b0);
      chk("wrap_busy", 192'(bza), 192'(1));
      req_edge(1'b0, 1);
      chk("wrap_e1_led0", 192'(la[0]), 192'(24'hFF8040));
      chk("wrap_e1_led7", 192'(la[7]), 192'(24'h7F4020));
      chk("wrap_e1_led6", 192'(la[6]), 192'(24'h7F4020));
      chk("wrap_e1_led1", 192'(la[1]), 192'(0));
      req_edge(1'b0, 1);
      chk("wrap_e2_led1", 192'(la[1]), 192'(24'hFF8040));
      chk("wrap_e2_led0", 192'(la[0]), 192'(24'h7F4020));
      chk("wrap_e2_led7", 192'(la[7]), 192'(24'h7F4020));
      for (int i = 3; i <= 9; i++) req_edge(1'b0, 1);
      chk("wrap_e9_led0", 192'(la[0]), 192'(24'hFF8040));
      chk("wrap_e9_led6", 192'(la[6]), 192'(24'h7F4020));

      // Stop then blank
      do_stop();
      chk("drain_busy", 192'(bza), 192'(1));
      req_edge(1'b0, 1);
      chk("blank_busy", 192'(bza), 192'(0));
      chk("blank_leds", 192'(pack8(la)), 192'(0));
      req_edge(1'b0, 1);

      // Bounce
      do_start(24'h00FF80, 4'd2, 1'b0, 1'b1, 1'b0);
      req_edge(1'b0, 1);
      chk("bnc_e1", 192'(pack8(la)), 192'(24'h00FF80));
      for (int i = 2; i <= 8; i++) req_edge(1'b0, 1);
      chk("bnc_e8_led7", 192'(la[7]), 192'(24'h00FF80));
      chk("bnc_e8_led6", 192'(la[6]), 192'(24'h007F40));
      req_edge(1'b0, 1);
      chk("bnc_e9_led6", 192'(la[6]), 192'(24'h00FF80));
      chk("bnc_e9_led7", 192'(la[7]), 192'(24'h007F40));
      chk("bnc_e9_head", 192'(hpa), 192'(5));
      for (int i = 10; i <= 16; i++) req_edge(1'b0, 1);
      chk("bnc_e16_led1", 192'(la[1]), 192'(24'h00FF80));
      chk("bnc_e16_led0", 192'(la[0]), 192'(24'h007F40));
      do_stop();
      req_edge(1'b0, 1);

      // Divider with a held request level
      do_start(24'h123456, 4'd2, 1'b0, 1'b0, 1'b0);
      for (int i = 1; i <= 3; i++) req_edge(1'b0, 1);
      req_edge(1'b0, 6);
      chk("div_e4_led0", 192'(lb[0]), 192'(24'h123456));
      chk("div_e4_head", 192'(hpb), 192'(1));
      req_edge(1'b0, 1);
      chk("div_e5_led1", 192'(lb[1]), 192'(24'h123456));

      // Request together with stop, then blank
      req_edge(1'b1, 1);
      chk("rqstop_busy", 192'(bzb), 192'(1));
      req_edge(1'b0, 1);
      chk("rqstop_blank_busy", 192'(bzb), 192'(0));

      // start+stop in idle
      do_start(24'hABCDEF, 4'd3, 1'b0, 1'b0, 1'b1);
      chk("startstop_idle_busy", 192'(bza), 192'(0));
      req_edge(1'b0, 1);

      // Length clamp
      do_start(24'h0000FF, 4'd0, 1'b1, 1'b0, 1'b0);
      req_edge(1'b0, 1);
      chk("len0_only_head", 192'(pack8(la)), {24'h0000FF, 168'h0});
      do_stop();
      req_edge(1'b0, 1);
      do_start(24'hFF8040, 4'd12, 1'b0, 1'b0, 1'b0);
      req_edge(1'b0, 1);
      n7 = 0;
      for (int i = 0; i < 8; i++) if (la[i] === 24'h7F4020) n7++;
      chk("len12_head", 192'(la[0]), 192'(24'hFF8040));
      chk("len12_tails", 192'(n7), 192'(7));
      do_stop();
      req_edge(1'b0, 1);

      // Asynchronous reset mid-run
      do_start(24'hFF8040, 4'd3, 1'b0, 1'b0, 1'b0);
      req_edge(1'b0, 1);
      req_edge(1'b0, 1);
      @(posedge clk);
      #2 rst = 1'b1;
      #1;
      chk("arst_leds_a", 192'(pack8(la)), 192'(0));
      chk("arst_leds_b", 192'(pack8(lb)), 192'(0));
      chk("arst_head", 192'(hpa), 192'(0));
      chk("arst_busy", 192'(bza), 192'(0));
      for (int d = 0; d < 2; d++) begin m_st[d] = 0; m_head[d] = 0; m_div[d] = 0; end
      qa.delete(); qb.delete();
      repeat (2) @(negedge clk);
      rst = 1'b0;
      req_edge(1'b0, 1);
      chk("post_rst_busy", 192'(bza), 192'(0));
      do_start(24'h00FF00, 4'd1, 1'b0, 1'b0, 1'b0);
      req_edge(1'b0, 1);
      chk("post_rst_led0", 192'(la[0]), 192'(24'h00FF00));
      repeat (2) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
